// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO register pair and its multiply/divide engine.
package hilo_pkg;
    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the unsigned engine: MSB-first shift-add multiply or restoring divide.
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    output logic [2*WIDTH-1:0]   acc_nxt,
    output logic [WIDTH-1:0]     opa_nxt
);
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] diff;

    // Divide keeps its WIDTH+1 bit partial remainder in the low bits of acc.
    assign r_shift = {acc[WIDTH-1:0], opa[WIDTH-1]};
    assign diff    = {1'b0, r_shift} - {2'b00, opb};

    always_comb begin
        acc_nxt = acc << 1;
        opa_nxt = opa << 1;
        if (is_div) begin
            if (diff[WIDTH+1]) begin
                acc_nxt = {{(WIDTH-1){1'b0}}, r_shift};
                opa_nxt = {opa[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = {{(WIDTH-1){1'b0}}, diff[WIDTH:0]};
                opa_nxt = {opa[WIDTH-2:0], 1'b1};
            end
        end else if (opa[WIDTH-1]) begin
            acc_nxt = (acc << 1) + {{WIDTH{1'b0}}, opb};
        end
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with single-cycle MTHI/MTLO and an iterative mul/div engine
// that works on magnitudes and applies signs in a final FIX cycle.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt, prod_fix;
    logic [WIDTH-1:0]   opa, opb, opa_nxt;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
    logic               is_div_q, neg_res, neg_rem, div_zero;
    logic               accept, op_mul, op_div, a_neg, b_neg;

    assign accept = start && (state == IDLE);
    assign op_mul = (op == OP_MULTU) || (op == OP_MULT);
    assign op_div = (op == OP_DIVU) || (op == OP_DIV);
    assign a_neg  = op[0] && src_a[WIDTH-1];
    assign b_neg  = op[0] && src_b[WIDTH-1];
    // Magnitude of MIN stays as the unsigned pattern 100..0, which is exactly right.
    assign abs_a  = a_neg ? -src_a : src_a;
    assign abs_b  = b_neg ? -src_b : src_b;

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);

    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = neg_res ? -opa : opa;
    assign rem_fix  = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (state == DIV),
        .acc     (acc),
        .opa     (opa),
        .opb     (opb),
        .acc_nxt (acc_nxt),
        .opa_nxt (opa_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && op_mul)      state_nxt = MUL;
                else if (accept && op_div) state_nxt = DIV;
            end
            MUL, DIV: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && op == OP_MTHI) hi <= src_a;
                    if (accept && op == OP_MTLO) lo <= src_a;
                    if (accept && (op_mul || op_div)) begin
                        acc      <= '0;
                        opa      <= abs_a;
                        opb      <= abs_b;
                        cnt      <= CW'(WIDTH);
                        is_div_q <= op_div;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (src_b == '0);
                    end
                end
                MUL, DIV: begin
                    acc <= acc_nxt;
                    opa <= opa_nxt;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    // Divide by zero: the remainder path already yields src_a; only lo needs forcing.
                    if (is_div_q) begin
                        hi <= rem_fix;
                        lo <= div_zero ? '1 : quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (WIDTH=32) with hand-computed results.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        ready, busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one mul/div, scramble operands while busy, and watch a fixed window.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int   busy_n, done_n, done_at;
        logic rdy_at_done;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1 start = 1'b0; src_a = $urandom; src_b = $urandom;
        busy_n = 0; done_n = 0; done_at = -1; rdy_at_done = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
                rdy_at_done = ready;
            end
        end
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
        chk({tag, "_done_latency"}, 64'(done_at), 64'd33);
        chk({tag, "_ready_with_done"}, 64'(rdy_at_done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_n;
        reset = 1'b1; start = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;

        run_op("mult_m1x2",   OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu_m1x2",  OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
        run_op("div_m7d2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_100d7",  OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        run_op("divu_by0",    OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
        run_op("div_by0",     OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("mult_minmin", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        // MTHI then MTLO back to back, then a MULT with an MTHI attempt while busy.
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; src_a = 32'hAABBCCDD;
        @(negedge clk);
        chk("mthi_hi", 64'(hi), 64'hAABBCCDD);
        chk("mthi_done", 64'(done), 64'd0);
        chk("mthi_busy", 64'(busy), 64'd0);
        op = OP_MTLO; src_a = 32'h11223344;
        @(negedge clk);
        chk("mtlo_lo", 64'(lo), 64'h11223344);
        chk("mtlo_hi", 64'(hi), 64'hAABBCCDD);
        chk("mtlo_done", 64'(done), 64'd0);
        chk("mtlo_ready", 64'(ready), 64'd1);
        op = OP_MULT; src_a = 32'd3; src_b = 32'hFFFFFFFC;
        @(posedge clk);
        #1 start = 1'b0;
        done_n = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (done) done_n++;
            if (i == 4) begin
                start = 1'b1; op = OP_MTHI; src_a = 32'h0000DEAD;
            end
            if (i == 6) start = 1'b0;
            if (i == 10) begin
                chk("midop_hi", 64'(hi), 64'hAABBCCDD);
                chk("midop_lo", 64'(lo), 64'h11223344);
                chk("midop_busy", 64'(busy), 64'd1);
            end
        end
        chk("mult_3xm4_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_3xm4_lo", 64'(lo), 64'hFFFFFFF4);
        chk("mult_3xm4_done", 64'(done_n), 64'd1);

        // Reserved op is a no-op.
        @(negedge clk);
        start = 1'b1; op = 3'b110; src_a = 32'h12345678; src_b = 32'h9;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("rsvd_ready", 64'(ready), 64'd1);
        chk("rsvd_busy", 64'(busy), 64'd0);
        chk("rsvd_hi", 64'(hi), 64'hFFFFFFFF);
        chk("rsvd_lo", 64'(lo), 64'hFFFFFFF4);

        // Asynchronous reset at iteration 10 of a MULT.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        chk("arst_ready", 64'(ready), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'h00000000, 32'h0000000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
